// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write-port arbiter: priority source A, FIFO-buffered source B
module wb_write_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    a_valid,
   input  logic [AW-1:0]           a_addr,
   input  logic [DW-1:0]           a_data,
   input  logic                    b_valid,
   output logic                    b_ready,
   input  logic [AW-1:0]           b_addr,
   input  logic [DW-1:0]           b_data,
   output logic                    rf_we,
   output logic [AW-1:0]           rf_waddr,
   output logic [DW-1:0]           rf_wdata,
   input  logic [AW-1:0]           pend_addr,
   output logic                    pend_hit,
   output logic [$clog2(DEPTH):0]  fifo_count
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int IW = PW - 1;
   localparam logic [PW-1:0] FULL = PW'(DEPTH);

   logic [AW-1:0]    mem_addr [DEPTH];
   logic [DW-1:0]    mem_data [DEPTH];
   logic [DEPTH-1:0] mem_live;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [IW-1:0]    hidx;
   logic [IW-1:0]    tidx;
   logic             a_act;
   logic             b_acc;
   logic             push;
   logic             pop;

   assign hidx       = head[IW-1:0];
   assign tidx       = tail[IW-1:0];
   assign fifo_count = tail - head;
   assign b_ready    = rst_n & (fifo_count < FULL);
   assign a_act      = a_valid & (a_addr != '0);
   assign b_acc      = b_valid & b_ready;
   assign push       = b_acc & (b_addr != '0);
   assign pop        = ~a_act & (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[tidx] <= b_addr;
         mem_data[tidx] <= b_data;
      end
   end

   // live is cleared on pop, so a set live bit always marks an occupied slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         mem_live <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (a_act && mem_live[i] && (mem_addr[i] == a_addr)) begin
               mem_live[i] <= 1'b0;
            end
         end
         if (pop) begin
            mem_live[hidx] <= 1'b0;
            head           <= head + 1'b1;
         end
         // a same-cycle push is younger than A, so it is set after the squash
         if (push) begin
            mem_live[tidx] <= 1'b1;
            tail           <= tail + 1'b1;
         end
         if (a_act) begin
            rf_we    <= 1'b1;
            rf_waddr <= a_addr;
            rf_wdata <= a_data;
         end else if (pop) begin
            rf_we    <= mem_live[hidx];
            rf_waddr <= mem_addr[hidx];
            rf_wdata <= mem_data[hidx];
         end else begin
            rf_we    <= 1'b0;
         end
      end
   end

   always_comb begin
      pend_hit = 1'b0;
      if (pend_addr != '0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_live[i] && (mem_addr[i] == pend_addr)) begin
               pend_hit = 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - self-checking bench for wb_write_arbiter
module tb_wb_write_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  pend_addr;
   logic        pend_hit;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
   } vec_t;
   vec_t vecs[6];

   wb_write_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_addr(pend_addr), .pend_hit(pend_hit), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      exp_q.push_back(w);
   endtask

   task automatic idle();
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
   endtask

   // scoreboard: every register-file write must match the next expected one
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         wr_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_write got addr=%0d data=%h exp=none", rf_waddr, rf_wdata);
         end else begin
            e = exp_q.pop_front();
            if (rf_waddr !== e.a || rf_wdata !== e.d) begin
               errors++;
               $display("FAIL sb_write got addr=%0d data=%h exp addr=%0d data=%h",
                        rf_waddr, rf_wdata, e.a, e.d);
            end
         end
      end
   end

   initial begin
      vecs[0] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd3,  32'h11};
      vecs[1] = '{1'b1, 5'd0,  32'h22,       1'b0, 5'd3,  32'h11};
      vecs[2] = '{1'b0, 5'd9,  32'h33,       1'b0, 5'd3,  32'h11};
      vecs[3] = '{1'b1, 5'd31, 32'hdeadbeef, 1'b1, 5'd31, 32'hdeadbeef};
      vecs[4] = '{1'b1, 5'd1,  32'h5,        1'b1, 5'd1,  32'h5};
      vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  32'h5};

      idle();
      pend_addr = '0;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_b_ready", 32'(b_ready), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("b_ready_after_rst", 32'(b_ready), 32'd1);

      // A-only vectors
      for (int i = 0; i < 6; i++) begin
         a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
         if (vecs[i].we) expect_wr(vecs[i].wa, vecs[i].wd);
         tick();
         chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].we));
         chk($sformatf("vec%0d_addr", i), 32'(rf_waddr), 32'(vecs[i].wa));
         chk($sformatf("vec%0d_data", i), rf_wdata, vecs[i].wd);
      end
      idle();

      // fill while A is busy, then drain in order
      for (int c = 0; c < 4; c++) begin
         a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h100 + c;
         b_valid = 1'b1; b_addr = 5'(8 + c); b_data = 32'h800 + c;
         expect_wr(5'd1, 32'h100 + c);
         #1;
         chk($sformatf("fill%0d_b_ready", c), 32'(b_ready), 32'd1);
         tick();
      end
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_b_ready", 32'(b_ready), 32'd0);
      pend_addr = 5'd9;
      #1;
      chk("full_pend_hit9", 32'(pend_hit), 32'd1);
      pend_addr = 5'd12;
      #1;
      chk("full_pend_hit12", 32'(pend_hit), 32'd0);
      idle();
      for (int c = 0; c < 4; c++) expect_wr(5'(8 + c), 32'h800 + c);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("drain%0d_we", c), 32'(rf_we), 32'd1);
         chk($sformatf("drain%0d_addr", c), 32'(rf_waddr), 32'(8 + c));
      end
      tick();
      chk("drained_we", 32'(rf_we), 32'd0);
      chk("drained_count", 32'(fifo_count), 32'd0);

      // WAW squash
      pend_addr = 5'd5;
      b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hAA;
      tick();
      chk("sq_pend_before", 32'(pend_hit), 32'd1);
      idle();
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hBB;
      expect_wr(5'd5, 32'hBB);
      tick();
      chk("sq_a_data", rf_wdata, 32'hBB);
      chk("sq_pend_after", 32'(pend_hit), 32'd0);
      chk("sq_count", 32'(fifo_count), 32'd1);
      idle();
      tick();
      chk("sq_pop_we", 32'(rf_we), 32'd0);
      chk("sq_pop_count", 32'(fifo_count), 32'd0);

      // r0 handling
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h3;
      tick();
      idle();
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h99;
      expect_wr(5'd7, 32'h3);
      tick();
      chk("r0_a_we", 32'(rf_we), 32'd1);
      chk("r0_a_addr", 32'(rf_waddr), 32'd7);
      idle();
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h44;
      #1;
      chk("r0_b_ready", 32'(b_ready), 32'd1);
      tick();
      idle();
      chk("r0_b_count", 32'(fifo_count), 32'd0);
      tick();
      chk("r0_b_we", 32'(rf_we), 32'd0);

      // reset mid-operation
      for (int c = 0; c < 3; c++) begin
         a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h200 + c;
         b_valid = 1'b1; b_addr = 5'(12 + c); b_data = 32'hC00 + c;
         expect_wr(5'd2, 32'h200 + c);
         tick();
      end
      chk("mid_count", 32'(fifo_count), 32'd3);
      idle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_b_ready", 32'(b_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_we", 32'(rf_we), 32'd0);
      pend_addr = 5'd13;
      #1;
      chk("mid_rst_pend", 32'(pend_hit), 32'd0);
      for (int c = 0; c < 5; c++) tick();
      chk("mid_rst_no_write", 32'(rf_we), 32'd0);

      // same-cycle A and B to the same register
      pend_addr = 5'd6;
      a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h1;
      b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h2;
      expect_wr(5'd6, 32'h1);
      expect_wr(5'd6, 32'h2);
      #1;
      chk("same_pend_push_cycle", 32'(pend_hit), 32'd0);
      tick();
      chk("same_first_data", rf_wdata, 32'h1);
      chk("same_pend_queued", 32'(pend_hit), 32'd1);
      idle();
      tick();
      chk("same_second_data", rf_wdata, 32'h2);
      chk("same_pend_popped", 32'(pend_hit), 32'd0);
      tick();
      @(negedge clk);
      #1;

      chk("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
